// File: rtl/spi_master_ctrl_if.sv
// Host command/response handshake plus the SPI pins of spi_master_ctrl.
// The controller uses modport master; the host or bench side uses modport slave.
interface spi_master_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_payload;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  cmd_valid, cmd_op, cmd_payload, MISO,
        output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_payload, MISO,
        input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: turns host RAM commands into 10-bit slave frames and returns read bytes.
// Optional macro SPI_MASTER_AUTO_RD_EN: every rd-addr frame is followed by an automatic rd-data frame.
module spi_master_ctrl #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYC - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYC - 1);
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [9:0] word;
    logic [6:0] rx;
    logic       armed;
    logic       accept;
    logic       ss_n;
    logic       mosi;
`ifdef SPI_MASTER_AUTO_RD_EN
    logic       auto_pending;
`endif

    // armed keeps cmd_ready low for the reset cycle itself.
    assign bus.cmd_ready = armed && (state == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.SS_n      = ss_n;
    assign bus.MOSI      = mosi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ss_n       = 1'b1;
        mosi       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                ss_n       = 1'b0;
                mosi       = word[9];
                state_next = SHIFT;
                cnt_next   = 4'd9;
            end
            SHIFT: begin
                ss_n = 1'b0;
                mosi = word[cnt];
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else if (word[9:8] == OP_RD_DATA) begin
                    state_next = TURN;
                    cnt_next   = TURN_LOAD;
                end else begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            TURN: begin
                ss_n = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = RECV;
                    cnt_next   = 4'd7;
                end
            end
            RECV: begin
                ss_n = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
`ifdef SPI_MASTER_AUTO_RD_EN
                    state_next = auto_pending ? SELECT : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // The final RECV edge completes the byte and raises rsp_valid for the first GAP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            word          <= 10'd0;
            rx            <= 7'd0;
            armed         <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'd0;
`ifdef SPI_MASTER_AUTO_RD_EN
            auto_pending  <= 1'b0;
`endif
        end else begin
            armed         <= 1'b1;
            bus.rsp_valid <= 1'b0;
            if (accept) begin
                word <= {bus.cmd_op, bus.cmd_payload};
`ifdef SPI_MASTER_AUTO_RD_EN
                auto_pending <= (bus.cmd_op == OP_RD_ADDR);
`endif
            end
            if (state == RECV) begin
                rx <= {rx[5:0], bus.MISO};
                if (cnt == 4'd0) begin
                    bus.rsp_data  <= {rx, bus.MISO};
                    bus.rsp_valid <= 1'b1;
                end
            end
`ifdef SPI_MASTER_AUTO_RD_EN
            if ((state == GAP) && (cnt == 4'd0) && auto_pending) begin
                word         <= {OP_RD_DATA, 8'h00};
                auto_pending <= 1'b0;
            end
`endif
        end
    end
endmodule
